magic_nor_sequencer: RTL and testbench
======================================

Name: magic_nor_sequencer

Overview:
- Micro-op sequencer that executes a NOR/INV-mapped gate netlist, one gate at a time, on a MAGIC memristor crossbar.
- Fetches gate instructions from an internal program store.
- For each gate, issues a mandatory output-cell INIT (set to logic 1) and then the NOR/INV evaluate, using a valid/ready handshake to the crossbar driver.
- Sits between the host loader and the crossbar driver; one netlist evaluation runs per start pulse.

Parameters:
- ADDR_W, 6, crossbar cell address width.
- PROG_DEPTH, 64, program store entries (power of 2).
- PC_W, 6, log2(PROG_DEPTH).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- prog_we  in  1  program store write enable.
- prog_addr  in  PC_W  program store write address.
- prog_wdata  in  2+3*ADDR_W  instruction word {op[1:0], a, b, d}.
- start  in  1  one-cycle request to run the program from address 0.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at completion.
- xb_valid  out  1  crossbar command valid.
- xb_op  out  2  01 INIT, 10 NOR2, 11 INV, 00 idle.
- xb_a  out  ADDR_W  source cell A.
- xb_b  out  ADDR_W  source cell B (0 for INIT and INV).
- xb_d  out  ADDR_W  destination cell.
- xb_ready  in  1  crossbar accepts the command this cycle.
- gate_count  out  CNT_W  NOR2/INV evaluates completed in the last or current run.
- cycle_count  out  CNT_W  busy cycles in the last or current run.

Behaviour:
- Instruction op codes: 00 END, 01 NOR2 (d = NOR(a, b)), 10 INV (d = NOR(a)), 11 NOP (skip).
- Reset clears the FSM to IDLE and sets busy=0, done=0, xb_valid=0, xb_op=00, xb_a/b/d=0, gate_count=0, cycle_count=0, pc=0. Program store contents are not reset.
- Program store: synchronous write. A write takes effect when prog_we=1 and busy=0; writes while busy=1 are ignored. Read is synchronous, with 1-cycle latency.
- FSM states: IDLE, FETCH, INIT, EVAL, DONE.
- IDLE:
  - start=1 -> FETCH; pc=0; both counters cleared; busy=1 from the next cycle.
  - start while busy is ignored.
- FETCH (1 cycle): instruction at pc is registered at the end of the cycle.
  - END -> DONE.
  - NOP -> pc+1, stay in FETCH.
  - NOR2/INV -> INIT.
- INIT: xb_valid=1, xb_op=01, xb_d=d, xb_a=xb_b=0.
  - Hold all xb_* stable until xb_ready=1, then -> EVAL.
- EVAL: xb_valid=1, xb_op=10 or 11, xb_a=a, xb_b=b (0 for INV), xb_d=d.
  - On xb_ready=1: gate_count+1, pc+1, -> FETCH.
  - If pc was PROG_DEPTH-1, -> DONE instead (implicit END, no wrap).
- NOP at pc=PROG_DEPTH-1 also -> DONE.
- DONE (1 cycle): done=1, busy=0, xb_valid=0, -> IDLE. Counters hold until the next start.
- cycle_count increments in every FETCH/INIT/EVAL cycle; it saturates at all-ones and does not wrap. gate_count also saturates.
- xb_valid is never asserted in IDLE, FETCH or DONE. xb_op=00 whenever xb_valid=0.
- With xb_ready held at 1: each gate costs 3 cycles (FETCH, INIT, EVAL); END costs 1. N gates + END gives cycle_count=3N+1, and done is asserted 3N+2 cycles after start.
- rst asserted mid-run: the command is abandoned immediately, no done pulse, all outputs return to reset values the next cycle.
- start and rst high together: rst wins.
- prog_we and start in the same IDLE cycle: the write completes and the run starts; the fetch of that address sees the new data.

Test Plan:
- Reset: assert rst 2 cycles with xb_ready=1 -> busy=0, done=0, xb_valid=0, counters=0.
- XOR of cells 0,1 into cell 5. Program: NOR2 a0 b1 d2; NOR2 a0 b2 d3; NOR2 a1 b2 d4; NOR2 a3 b4 d6; INV a6 d5; END. Run with xb_ready=1 -> command sequence INIT d2, NOR2 0,1,2, ..., INIT d5, INV 6->5; gate_count=5, cycle_count=16, done exactly 17 cycles after start.
- Backpressure: single NOR2 gate, xb_ready=0 for 4 cycles during INIT and 2 cycles during EVAL -> xb_* stable throughout each stall; cycle_count=1+5+3+1=10.
- NOP skipping and implicit end: fill all 64 entries with NOP except entry 63 = INV a7 d8 -> one INIT/INV pair issued, gate_count=1, then DONE without wrap.
- Busy protection: during a run, pulse start and write entry 0 -> run unaffected, entry 0 unchanged when read back in the next run.
- Reset mid-EVAL with xb_valid=1 -> next cycle xb_valid=0, busy=0, no done pulse; a subsequent start re-runs from pc=0.

Source files
------------

// File: rtl/magic_nor_sequencer_if.sv
// Host/crossbar-facing signal bundle for the MAGIC NOR sequencer.
// The slave view belongs to the sequencer. The master view belongs to
// whatever drives the loader/start side and models the crossbar driver.
interface magic_nor_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int PC_W   = 6,
  parameter int CNT_W  = 16
);
  logic                    prog_we;
  logic [PC_W-1:0]         prog_addr;
  logic [2+3*ADDR_W-1:0]   prog_wdata;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    xb_valid;
  logic [1:0]              xb_op;
  logic [ADDR_W-1:0]       xb_a;
  logic [ADDR_W-1:0]       xb_b;
  logic [ADDR_W-1:0]       xb_d;
  logic                    xb_ready;
  logic [CNT_W-1:0]        gate_count;
  logic [CNT_W-1:0]        cycle_count;

  modport slave (
    input  prog_we, prog_addr, prog_wdata, start, xb_ready,
    output busy, done, xb_valid, xb_op, xb_a, xb_b, xb_d,
           gate_count, cycle_count
  );

  modport master (
    output prog_we, prog_addr, prog_wdata, start, xb_ready,
    input  busy, done, xb_valid, xb_op, xb_a, xb_b, xb_d,
           gate_count, cycle_count
  );
endinterface

// File: rtl/magic_nor_sequencer.sv
// MAGIC crossbar micro-op sequencer. It walks a NOR/INV gate program held in a
// local store. For every gate it issues an output-cell INIT followed by the
// NOR2/INV evaluate over a valid/ready link. Every output is registered.
// Each output is computed from the next state, so it lines up with the state
// register.
module magic_nor_sequencer #(
  parameter int ADDR_W     = 6,
  parameter int PROG_DEPTH = 64,
  parameter int PC_W       = 6,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  magic_nor_sequencer_if.slave  bus
);

  localparam int IW = 2 + 3 * ADDR_W;

  // Program op codes.
  localparam logic [1:0] OP_END  = 2'b00;
  localparam logic [1:0] OP_NOR2 = 2'b01;
  localparam logic [1:0] OP_INV  = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  // Crossbar command codes.
  localparam logic [1:0] XB_IDLE = 2'b00;
  localparam logic [1:0] XB_INIT = 2'b01;
  localparam logic [1:0] XB_NOR2 = 2'b10;
  localparam logic [1:0] XB_INV  = 2'b11;

  localparam logic [PC_W-1:0]  PC_LAST = PC_W'(PROG_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_INIT  = 3'd2,
    S_EVAL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Instruction field helpers for the {op, a, b, d} layout.
  function automatic logic [1:0] f_op(input logic [IW-1:0] w);
    return w[IW-1 -: 2];
  endfunction

  function automatic logic [ADDR_W-1:0] f_a(input logic [IW-1:0] w);
    return w[3*ADDR_W-1 -: ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] f_b(input logic [IW-1:0] w);
    return w[2*ADDR_W-1 -: ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] f_d(input logic [IW-1:0] w);
    return w[ADDR_W-1:0];
  endfunction

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [IW-1:0]     mem [PROG_DEPTH];
  logic [IW-1:0]     rd_data_r;
  logic              wr_en_s;

  state_t            state_r,    state_s;
  logic [PC_W-1:0]   pc_r,       pc_s;
  logic [IW-1:0]     instr_r,    instr_s;
  logic [CNT_W-1:0]  gate_cnt_r, gate_cnt_s;
  logic [CNT_W-1:0]  cyc_cnt_r,  cyc_cnt_s;
  logic              busy_r,     busy_s;
  logic              done_r,     done_s;
  logic              xb_valid_r, xb_valid_s;
  logic [1:0]        xb_op_r,    xb_op_s;
  logic [ADDR_W-1:0] xb_a_r,     xb_a_s;
  logic [ADDR_W-1:0] xb_b_r,     xb_b_s;
  logic [ADDR_W-1:0] xb_d_r,     xb_d_s;

  // The host may load the store only while no run is in flight.
  assign wr_en_s = bus.prog_we & ~busy_r;

  // Program store write port. The contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[bus.prog_addr] <= bus.prog_wdata;
    end
  end

  // Read port, addressed by the next pc so the word is ready during FETCH.
  // A write in the same cycle is forwarded, which covers a load together
  // with start.
  always_ff @(posedge clk) begin
    if (wr_en_s && (bus.prog_addr == pc_s)) begin
      rd_data_r <= bus.prog_wdata;
    end else begin
      rd_data_r <= mem[pc_s];
    end
  end

  // Next-state, pc, counter and registered-output decode.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    instr_s    = instr_r;
    gate_cnt_s = gate_cnt_r;
    cyc_cnt_s  = cyc_cnt_r;

    if ((state_r == S_FETCH) || (state_r == S_INIT) || (state_r == S_EVAL)) begin
      cyc_cnt_s = sat_inc(cyc_cnt_r);
    end else begin
      cyc_cnt_s = cyc_cnt_r;
    end

    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_s    = S_FETCH;
          pc_s       = {PC_W{1'b0}};
          gate_cnt_s = {CNT_W{1'b0}};
          cyc_cnt_s  = {CNT_W{1'b0}};
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        instr_s = rd_data_r;
        case (f_op(rd_data_r))
          OP_END: state_s = S_DONE;
          OP_NOP: begin
            if (pc_r == PC_LAST) begin
              state_s = S_DONE;
            end else begin
              pc_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
            end
          end
          OP_NOR2: state_s = S_INIT;
          OP_INV:  state_s = S_INIT;
          default: state_s = S_DONE;
        endcase
      end
      S_INIT: begin
        if (bus.xb_ready) begin
          state_s = S_EVAL;
        end else begin
          state_s = S_INIT;
        end
      end
      S_EVAL: begin
        if (bus.xb_ready) begin
          gate_cnt_s = sat_inc(gate_cnt_r);
          if (pc_r == PC_LAST) begin
            state_s = S_DONE;
          end else begin
            state_s = S_FETCH;
            pc_s    = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_s = S_EVAL;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase

    busy_s     = (state_s == S_FETCH) || (state_s == S_INIT) || (state_s == S_EVAL);
    done_s     = (state_s == S_DONE);
    xb_valid_s = 1'b0;
    xb_op_s    = XB_IDLE;
    xb_a_s     = {ADDR_W{1'b0}};
    xb_b_s     = {ADDR_W{1'b0}};
    xb_d_s     = {ADDR_W{1'b0}};

    case (state_s)
      S_INIT: begin
        xb_valid_s = 1'b1;
        xb_op_s    = XB_INIT;
        xb_d_s     = f_d(instr_s);
      end
      S_EVAL: begin
        xb_valid_s = 1'b1;
        xb_a_s     = f_a(instr_s);
        xb_d_s     = f_d(instr_s);
        if (f_op(instr_s) == OP_INV) begin
          xb_op_s = XB_INV;
          xb_b_s  = {ADDR_W{1'b0}};
        end else begin
          xb_op_s = XB_NOR2;
          xb_b_s  = f_b(instr_s);
        end
      end
      default: begin
        xb_valid_s = 1'b0;
        xb_op_s    = XB_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset abandons any command at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      pc_r       <= {PC_W{1'b0}};
      instr_r    <= {IW{1'b0}};
      gate_cnt_r <= {CNT_W{1'b0}};
      cyc_cnt_r  <= {CNT_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      xb_valid_r <= 1'b0;
      xb_op_r    <= XB_IDLE;
      xb_a_r     <= {ADDR_W{1'b0}};
      xb_b_r     <= {ADDR_W{1'b0}};
      xb_d_r     <= {ADDR_W{1'b0}};
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      instr_r    <= instr_s;
      gate_cnt_r <= gate_cnt_s;
      cyc_cnt_r  <= cyc_cnt_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      xb_valid_r <= xb_valid_s;
      xb_op_r    <= xb_op_s;
      xb_a_r     <= xb_a_s;
      xb_b_r     <= xb_b_s;
      xb_d_r     <= xb_d_s;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.xb_valid    = xb_valid_r;
  assign bus.xb_op       = xb_op_r;
  assign bus.xb_a        = xb_a_r;
  assign bus.xb_b        = xb_b_r;
  assign bus.xb_d        = xb_d_r;
  assign bus.gate_count  = gate_cnt_r;
  assign bus.cycle_count = cyc_cnt_r;

endmodule

// File: tb/tb_magic_nor_sequencer.sv
// Directed bench for magic_nor_sequencer: XOR netlist, backpressure,
// NOP skipping with implicit end, busy protection, and reset during a run.
module tb_magic_nor_sequencer;
  localparam int ADDR_W = 6;
  localparam int PC_W   = 6;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   lat;

  logic [19:0] log_q[$];
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  magic_nor_sequencer_if #(.ADDR_W(ADDR_W), .PC_W(PC_W), .CNT_W(CNT_W)) sif ();

  magic_nor_sequencer #(
    .ADDR_W(ADDR_W), .PROG_DEPTH(64), .PC_W(PC_W), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  // Record every command the crossbar accepts.
  always @(posedge clk) begin
    if (sif.xb_valid && sif.xb_ready) log_q.push_back({sif.xb_op, sif.xb_a, sif.xb_b, sif.xb_d});
  end

  function automatic logic [19:0] w(input logic [1:0] op, input int a, input int b, input int d);
    return {op, 6'(a), 6'(b), 6'(d)};
  endfunction

  function automatic logic [31:0] cmdv(input logic v, input logic [1:0] op, input int a, input int b, input int d);
    return {11'd0, v, op, 6'(a), 6'(b), 6'(d)};
  endfunction

  function automatic logic [31:0] obs_cmd();
    return {11'd0, sif.xb_valid, sif.xb_op, sif.xb_a, sif.xb_b, sif.xb_d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write(input int addr, input logic [19:0] data);
    sif.prog_we    = 1'b1;
    sif.prog_addr  = 6'(addr);
    sif.prog_wdata = data;
    tick();
    sif.prog_we    = 1'b0;
  endtask

  // Pulse start, then wait (bounded) for done; lat counts cycles since start.
  task automatic run(input int limit, output int l);
    log_q.delete();
    sif.start = 1'b1;
    tick();
    sif.start   = 1'b0;
    sif.prog_we = 1'b0;
    l = 1;
    while (sif.done !== 1'b1 && l < limit) begin
      tick();
      l++;
    end
  endtask

  task automatic wait_done(input int limit, inout int l);
    while (sif.done !== 1'b1 && l < limit) begin
      tick();
      l++;
    end
  endtask

  task automatic check_log(input string tag);
    logic [19:0] e;
    check({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      e = (i < log_q.size()) ? log_q[i] : 20'hFFFFF;
      check($sformatf("%s_cmd%0d", tag, i), 32'(e), 32'(exp_q[i]));
    end
  endtask

  task automatic check_end(input string tag, input int l, input int exp_lat, input int gates, input int cycles);
    check({tag, "_done"}, 32'(sif.done), 32'd1);
    check({tag, "_lat"}, 32'(l), 32'(exp_lat));
    check({tag, "_gates"}, 32'(sif.gate_count), 32'(gates));
    check({tag, "_cycles"}, 32'(sif.cycle_count), 32'(cycles));
    check({tag, "_busy_at_done"}, 32'(sif.busy), 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(sif.done), 32'd0);
    check({tag, "_cnt_hold"}, 32'(sif.cycle_count), 32'(cycles));
  endtask

  initial begin
    sif.prog_we    = 1'b0;
    sif.prog_addr  = 6'd0;
    sif.prog_wdata = 20'd0;
    sif.start      = 1'b0;
    sif.xb_ready   = 1'b1;

    // Reset held two cycles
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(sif.busy), 32'd0);
    check("rst_done", 32'(sif.done), 32'd0);
    check("rst_cmd", obs_cmd(), cmdv(1'b0, 2'b00, 0, 0, 0));
    check("rst_gates", 32'(sif.gate_count), 32'd0);
    check("rst_cycles", 32'(sif.cycle_count), 32'd0);
    rst = 1'b0;
    tick();

    // XOR of cells 0,1 into cell 5
    write(0, w(2'b01, 0, 1, 2));
    write(1, w(2'b01, 0, 2, 3));
    write(2, w(2'b01, 1, 2, 4));
    write(3, w(2'b01, 3, 4, 6));
    write(4, w(2'b10, 6, 0, 5));
    write(5, w(2'b00, 0, 0, 0));
    run(100, lat);
    exp_q = '{w(2'b01, 0, 0, 2), w(2'b10, 0, 1, 2),
              w(2'b01, 0, 0, 3), w(2'b10, 0, 2, 3),
              w(2'b01, 0, 0, 4), w(2'b10, 1, 2, 4),
              w(2'b01, 0, 0, 6), w(2'b10, 3, 4, 6),
              w(2'b01, 0, 0, 5), w(2'b11, 6, 0, 5)};
    check_log("xor");
    check_end("xor", lat, 17, 5, 16);

    // Backpressure on a single NOR2 gate
    write(0, w(2'b01, 9, 10, 11));
    write(1, w(2'b00, 0, 0, 0));
    sif.xb_ready = 1'b0;
    log_q.delete();
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    check("bp_fetch_cmd", obs_cmd(), cmdv(1'b0, 2'b00, 0, 0, 0));
    check("bp_fetch_busy", 32'(sif.busy), 32'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_init%0d", i), obs_cmd(), cmdv(1'b1, 2'b01, 0, 0, 11));
      sif.xb_ready = (i == 4);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_eval%0d", i), obs_cmd(), cmdv(1'b1, 2'b10, 9, 10, 11));
      sif.xb_ready = (i == 2);
      tick();
    end
    check("bp_end_fetch", obs_cmd(), cmdv(1'b0, 2'b00, 0, 0, 0));
    tick();
    check_end("bp", 11, 11, 1, 10);

    // All NOPs except an INV at the last entry: implicit end, no wrap
    for (int i = 0; i < 63; i++) write(i, w(2'b11, 0, 0, 0));
    write(63, w(2'b10, 7, 0, 8));
    run(200, lat);
    exp_q = '{w(2'b01, 0, 0, 8), w(2'b11, 7, 0, 8)};
    check_log("nop");
    check_end("nop", lat, 67, 1, 66);

    // Start pulse and store write while busy are ignored
    write(0, w(2'b01, 1, 2, 3));
    write(1, w(2'b00, 0, 0, 0));
    log_q.delete();
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    tick();
    sif.start      = 1'b1;
    sif.prog_we    = 1'b1;
    sif.prog_addr  = 6'd0;
    sif.prog_wdata = w(2'b01, 20, 21, 22);
    tick();
    sif.start   = 1'b0;
    sif.prog_we = 1'b0;
    lat = 3;
    wait_done(100, lat);
    exp_q = '{w(2'b01, 0, 0, 3), w(2'b10, 1, 2, 3)};
    check_log("busy1");
    check_end("busy1", lat, 5, 1, 4);
    run(100, lat);
    check_log("busy2");
    check_end("busy2", lat, 5, 1, 4);

    // Write and start in the same idle cycle: fetch sees the new word
    sif.prog_we    = 1'b1;
    sif.prog_addr  = 6'd0;
    sif.prog_wdata = w(2'b01, 4, 5, 6);
    run(100, lat);
    exp_q = '{w(2'b01, 0, 0, 6), w(2'b10, 4, 5, 6)};
    check_log("wrst");
    check_end("wrst", lat, 5, 1, 4);

    // Reset while EVAL is pending
    sif.xb_ready = 1'b0;
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    tick();
    check("mid_init", obs_cmd(), cmdv(1'b1, 2'b01, 0, 0, 6));
    sif.xb_ready = 1'b1;
    tick();
    sif.xb_ready = 1'b0;
    check("mid_eval", obs_cmd(), cmdv(1'b1, 2'b10, 4, 5, 6));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_cmd", obs_cmd(), cmdv(1'b0, 2'b00, 0, 0, 0));
    check("mid_rst_busy", 32'(sif.busy), 32'd0);
    check("mid_rst_gates", 32'(sif.gate_count), 32'd0);
    check("mid_rst_cycles", 32'(sif.cycle_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mid_rst_nodone%0d", i), 32'(sif.done), 32'd0);
      tick();
    end
    sif.xb_ready = 1'b1;
    run(100, lat);
    check_log("rerun");
    check_end("rerun", lat, 5, 1, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
